// File: rtl/mfcc_pkg.sv
// Shared definitions for the cepstral coefficient RAM arbiter.
// Latency: none (package only).
// Backpressure: n/a.
package mfcc_pkg;

    localparam int NUM_REQ        = 3;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_MAX_HOLD   = 15;
    localparam int HOLD_W         = 4;

    // Arbiter FSM encodings
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;

    typedef logic [1:0] port_idx_t;

    // Next port in round-robin order, wrapping 2 -> 0.
    function automatic port_idx_t rr_next(input port_idx_t idx);
        return (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/delta_mem_arbiter_rr_pick3.sv
// Combinational round-robin picker for three requesters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; masked-off requesters are simply skipped.
// Ports: i_req/i_mask select candidates, i_last is the previous winner
//        (scan starts just after it), o_gnt/o_idx is the winner, o_any
//        says whether any candidate was found.
module rr_pick3
    import mfcc_pkg::*;
(
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [NUM_REQ-1:0] i_mask,
    input  port_idx_t          i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output port_idx_t          o_idx,
    output logic               o_any
);

    logic [NUM_REQ-1:0] w_cand;
    port_idx_t          w_scan;

    always_comb begin
        w_cand = i_req & ~i_mask;
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_scan = rr_next(i_last);
        // First candidate at or after last+1 wins; i_last itself is
        // visited last so it ends up lowest priority.
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!o_any && w_cand[w_scan]) begin
                o_any         = 1'b1;
                o_idx         = w_scan;
                o_gnt[w_scan] = 1'b1;
            end
            w_scan = rr_next(w_scan);
        end
    end

endmodule

// File: rtl/delta_mem_arbiter.sv
// Round-robin owner arbiter for the single-port cepstral coefficient RAM.
// Latency: grant one cycle after request in IDLE; zero-bubble handover; read data one cycle after access.
// Backpressure: non-owners are stalled by withholding gnt; hold watchdog forces release after MAX_HOLD contended cycles.
// Ports: req/lock/we_i/addr_i/wdata_i per requester (packed, port i at slice i),
//        gnt one-hot registered grant, rvalid/rdata_o read return,
//        timeout_o watchdog pulse, mem_* RAM-side interface.
module delta_mem_arbiter
    import mfcc_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int MAX_HOLD   = DEF_MAX_HOLD
)(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            lock,
    input  logic [NUM_REQ-1:0]            we_i,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          timeout_o,
    output logic                          mem_en,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_wdata,
    input  logic [DATA_WIDTH-1:0]         mem_rdata
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    logic [0:0]          r_state;
    port_idx_t           r_owner;
    port_idx_t           r_last;
    logic [HOLD_W-1:0]   r_hold;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  r_rvalid;

    logic                w_owning;
    logic                w_owner_req;
    logic                w_owner_lock;
    logic                w_other;
    logic                w_force;
    logic                w_release;
    logic                w_arb;
    logic [NUM_REQ-1:0]  w_mask;
    logic [NUM_REQ-1:0]  w_pick_gnt;
    port_idx_t           w_pick_idx;
    logic                w_pick_any;

    assign w_owning     = (r_state == ST_OWN);
    assign w_owner_req  = w_owning && req[r_owner];
    assign w_owner_lock = w_owning && lock[r_owner];
    // Any requester other than the current owner is waiting.
    assign w_other      = |(req & ~r_gnt);

    // Watchdog fires in the cycle the contended hold count hits the limit;
    // ownership is dropped at the end of that cycle regardless of lock.
    assign w_force   = w_owning && w_other && (r_hold == HOLD_LIM);
    assign w_release = w_owning && (w_force || (!w_owner_req && !w_owner_lock));
    assign w_arb     = !w_owning || w_release;

    // The outgoing owner is never a candidate in the handover decision.
    assign w_mask = w_owning ? r_gnt : '0;

    rr_pick3 u_pick (
        .i_req  (req),
        .i_mask (w_mask),
        .i_last (r_last),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // RAM-side mux: only the granted port with its request high reaches the RAM.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_gnt[i] && req[i]) begin
                mem_en    = 1'b1;
                mem_we    = we_i[i];
                mem_addr  = addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
                mem_wdata = wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_owner  <= '0;
            r_last   <= 2'd2;
            r_hold   <= '0;
            r_gnt    <= '0;
            r_rvalid <= '0;
        end else begin
            // Read return is tagged with the port that issued it, so a
            // grant change on the same edge does not misroute the data.
            r_rvalid <= (mem_en && !mem_we) ? r_gnt : '0;

            if (w_arb) begin
                r_hold <= '0;
                if (w_pick_any) begin
                    r_state <= ST_OWN;
                    r_owner <= w_pick_idx;
                    r_last  <= w_pick_idx;
                    r_gnt   <= w_pick_gnt;
                end else begin
                    r_state <= ST_IDLE;
                    r_gnt   <= '0;
                end
            end else begin
                r_hold <= w_other ? r_hold + 4'd1 : '0;
            end
        end
    end

    assign gnt       = r_gnt;
    assign rvalid    = r_rvalid;
    assign rdata_o   = (|r_rvalid) ? mem_rdata : '0;
    assign timeout_o = w_force;

endmodule
